// File: rtl/fc_result_collector.sv
// rtl/fc_result_collector.sv - ping-pong result buffer at the consumer end of the fc output stream
//
// Captures M signed results per output vector into one of two banks. A bank that has
// been filled completely is offered to the reader through vec_valid/vec_ack. While
// the reader works on one bank, the fc block can stream the next vector into the
// other bank.
//
// Build option:
//   FC_COLLECT_RELU_EN  when defined, negative results are stored as 0 on capture.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   result word valid (from fc output_valid)
//   in_data    signed result word (from fc output_data)
//   in_ready   collector can accept a word (to fc output_ready)
//   vec_valid  a complete vector is readable in the current read bank
//   vec_ack    one-cycle pulse: the reader is done with the current read bank
//   rd_addr    element index within the current read bank
//   rd_data    registered read data, one cycle after rd_addr
module fc_result_collector #(
    parameter int M = 4,
    parameter int T = 16,
    localparam int LOGM = $clog2(M)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic signed [T-1:0] in_data,
    output logic                in_ready,
    output logic                vec_valid,
    input  logic                vec_ack,
    input  logic [LOGM-1:0]     rd_addr,
    output logic signed [T-1:0] rd_data
);

    localparam logic [LOGM-1:0] LAST_IDX = LOGM'(M - 1);
    localparam logic [LOGM:0]   M_EXT    = (LOGM + 1)'(M);

    // Number of banks holding a complete, unacknowledged vector.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_BOTH  = 2'd2
    } occ_t;

    occ_t            occ_q, occ_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [LOGM-1:0] wr_idx_q, wr_idx_d;
    logic [1:0]      full_q, full_d;

    logic signed [T-1:0] mem [2][M];

    logic                accept;
    logic                fill_done;
    logic                ack_fire;
    logic signed [T-1:0] wr_word;

    assign in_ready  = !full_q[wr_bank_q];
    assign vec_valid = full_q[rd_bank_q];
    assign accept    = in_valid && in_ready;
    assign fill_done = accept && (wr_idx_q == LAST_IDX);
    assign ack_fire  = vec_ack && vec_valid;

`ifdef FC_COLLECT_RELU_EN
    assign wr_word = in_data[T-1] ? '0 : in_data;
`else
    assign wr_word = in_data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q     <= OCC_EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            full_q    <= 2'b00;
        end else begin
            occ_q     <= occ_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            full_q    <= full_d;
        end
    end

    // A fill can only complete on a non-full bank and an ack only releases a full
    // bank, so when both happen in one cycle they act on different banks and both
    // updates below are applied independently.
    always_comb begin
        occ_d     = occ_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        full_d    = full_q;

        if (accept) begin
            wr_idx_d = fill_done ? '0 : wr_idx_q + 1'b1;
        end
        if (fill_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (ack_fire) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        case ({fill_done, ack_fire})
            2'b10: begin
                case (occ_q)
                    OCC_EMPTY: occ_d = OCC_ONE;
                    default:   occ_d = OCC_BOTH;
                endcase
            end
            2'b01: begin
                case (occ_q)
                    OCC_BOTH: occ_d = OCC_ONE;
                    default:  occ_d = OCC_EMPTY;
                endcase
            end
            default: occ_d = occ_q;
        endcase
    end

    // Storage is not reset; a partial vector is simply overwritten after reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank_q][wr_idx_q] <= wr_word;
        end
    end

    // Read port runs every cycle regardless of vec_valid; out-of-range
    // addresses (only possible when M is not a power of two) return 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < M_EXT) begin
            rd_data <= mem[rd_bank_q][rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule
